// File: rtl/lbm_collide_sched_if.sv
// Host-control, node-memory and collision-unit signals of the D2Q9 sweep scheduler.
// The scheduler takes the master side; memory, collision unit and host sit on the slave side.
interface lbm_collide_sched_if #(
   parameter int NODE_W = 11
);
   localparam int DATA_W = 144;

   logic              start;
   logic [15:0]       steps;
   logic              hold;
   logic              busy;
   logic              done;
   logic [15:0]       step_count;
   logic              rd_en;
   logic [NODE_W:0]   rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] col_f;
   logic [3:0]        col_bnd;
   logic [DATA_W-1:0] col_res;
   logic              wr_en;
   logic [NODE_W:0]   wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  start, steps, hold, rd_data, col_res,
      output busy, done, step_count, rd_en, rd_addr, col_f, col_bnd, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, steps, hold, rd_data, col_res,
      input  busy, done, step_count, rd_en, rd_addr, col_f, col_bnd, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/lbm_collide_sched.sv
// Row-major sweep scheduler for the D2Q9 collision datapath: reads each node from the source
// bank, feeds the collision unit, and writes the collided node to the opposite bank.
module lbm_collide_sched #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 32,
   parameter int NODE_W = 11,
   parameter int RD_LAT = 1
)(
   input  logic                clk,
   input  logic                reset,
   lbm_collide_sched_if.master bus
);
   localparam int DATA_W = 144;
   localparam int XW     = $clog2(WIDTH);
   localparam int YW     = $clog2(HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, STEP_END} state_t;

   state_t              state_q;
   logic [XW-1:0]       x_q;
   logic [YW-1:0]       y_q;
   logic [NODE_W-1:0]   idx_q;
   logic                src_bank_q;
   logic [15:0]         steps_q;
   logic [15:0]         step_count_q;
   logic                busy_q;
   logic                done_q;

   logic [RD_LAT-1:0]   vld_p0_q;
   logic [NODE_W-1:0]   idx_p0_q [RD_LAT];
   logic [3:0]          bnd_p0_q [RD_LAT];
   logic                vld_p1_q;
   logic [NODE_W-1:0]   idx_p1_q;
   logic [DATA_W-1:0]   col_f_q;
   logic [3:0]          col_bnd_q;
   logic                wr_en_q;
   logic [NODE_W:0]     wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;

   logic                issue;
   logic                pipe_busy;

   function automatic logic [3:0] bnd_code(input logic [XW-1:0] x, input logic [YW-1:0] y);
      logic l, r, t, b;
      l = (x == '0);
      r = (x == X_LAST);
      t = (y == '0);
      b = (y == Y_LAST);
      if (t && l)      return 4'd5;
      else if (t && r) return 4'd6;
      else if (b && l) return 4'd7;
      else if (b && r) return 4'd8;
      else if (l)      return 4'd1;
      else if (r)      return 4'd2;
      else if (t)      return 4'd3;
      else if (b)      return 4'd4;
      else             return 4'd0;
   endfunction

   assign issue     = (state_q == SWEEP) && !bus.hold;
   assign pipe_busy = (|vld_p0_q) || vld_p1_q || wr_en_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         idx_q        <= '0;
         src_bank_q   <= 1'b0;
         steps_q      <= '0;
         step_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A start coinciding with the done pulse belongs to the finished run.
               if (bus.start && !done_q) begin
                  steps_q      <= bus.steps;
                  step_count_q <= '0;
                  x_q          <= '0;
                  y_q          <= '0;
                  idx_q        <= '0;
                  if (bus.steps == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= SWEEP;
                     busy_q  <= 1'b1;
                  end
               end
            end
            SWEEP: begin
               if (!bus.hold) begin
                  idx_q <= idx_q + 1'b1;
                  if (x_q == X_LAST) begin
                     x_q <= '0;
                     if (y_q == Y_LAST) state_q <= DRAIN;
                     else               y_q     <= y_q + 1'b1;
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!pipe_busy) state_q <= STEP_END;
            end
            STEP_END: begin
               src_bank_q   <= ~src_bank_q;
               step_count_q <= step_count_q + 1'b1;
               x_q          <= '0;
               y_q          <= '0;
               idx_q        <= '0;
               if (step_count_q + 16'd1 == steps_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= SWEEP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            idx_p0_q[i] <= '0;
            bnd_p0_q[i] <= '0;
         end
         vld_p1_q  <= 1'b0;
         idx_p1_q  <= '0;
         col_f_q   <= '0;
         col_bnd_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         // p0: node tag rides alongside the memory read latency
         vld_p0_q[0] <= issue;
         idx_p0_q[0] <= idx_q;
         bnd_p0_q[0] <= bnd_code(x_q, y_q);
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p0_q[i] <= vld_p0_q[i-1];
            idx_p0_q[i] <= idx_p0_q[i-1];
            bnd_p0_q[i] <= bnd_p0_q[i-1];
         end
         // p1: register read data towards the collision unit
         vld_p1_q <= vld_p0_q[RD_LAT-1];
         if (vld_p0_q[RD_LAT-1]) begin
            col_f_q   <= bus.rd_data;
            col_bnd_q <= bnd_p0_q[RD_LAT-1];
            idx_p1_q  <= idx_p0_q[RD_LAT-1];
         end
         // p2: register collided node for write-back into the other bank
         wr_en_q <= vld_p1_q;
         if (vld_p1_q) begin
            wr_addr_q <= {~src_bank_q, idx_p1_q};
            wr_data_q <= bus.col_res;
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.step_count = step_count_q;
   assign bus.rd_en      = issue;
   assign bus.rd_addr    = {src_bank_q, idx_q};
   assign bus.col_f      = col_f_q;
   assign bus.col_bnd    = col_bnd_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
endmodule

// File: doc/lbm_collide_sched.md
# lbm_collide_sched

Sweep scheduler for the D2Q9 lattice-Boltzmann collision datapath. It walks every node of a WIDTH×HEIGHT grid in row-major order, for a requested number of time steps. For each node it reads the nine packed distributions from a double-banked node memory, presents them to the combinational collision unit together with the node's boundary code, and writes the collided result to the opposite bank. It sits between the host/top-level control and the node memory; streaming is handled downstream and is outside this block.

## Interface

Parameters:
- WIDTH, 64, grid columns (x), ≥ 2
- HEIGHT, 32, grid rows (y), ≥ 2
- NODE_W, 11, node-index width; must satisfy 2^NODE_W ≥ WIDTH·HEIGHT
- RD_LAT, 1, node-memory read latency in cycles (1..4)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a run; ignored while busy
- steps  in  16  number of time steps, sampled on accepted start
- hold  in  1  pauses read issue; in-flight nodes still drain
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle pulse when the run completes
- step_count  out  16  completed steps in the current/last run
- rd_en  out  1  node read strobe
- rd_addr  out  NODE_W+1  {bank, node index}
- rd_data  in  144  packed f0..f8, f_i at bits [16i+15:16i], signed 2.14
- col_f  out  144  registered distributions to the collision unit
- col_bnd  out  4  registered boundary code to the collision unit
- col_res  in  144  collision-unit output, same packing
- wr_en  out  1  node write strobe
- wr_addr  out  NODE_W+1  {bank, node index}
- wr_data  out  144  registered col_res

## Operation

- FSM states are IDLE, SWEEP, DRAIN, STEP_END.
- IDLE: on start=1, latch steps and clear step_count.
  - If steps=0, pulse done in the next cycle, stay in IDLE, and make no memory access.
  - Otherwise go to SWEEP with x=y=0.
- SWEEP: each cycle with hold=0, assert rd_en with rd_addr={src_bank, y·WIDTH+x}, then advance x.
  - When x wraps at WIDTH-1, x returns to 0 and y increments.
  - After node (WIDTH-1, HEIGHT-1) is issued, go to DRAIN.
  - hold=1 suppresses rd_en and freezes x and y.
- DRAIN: wait until the pipeline valid bits are all zero, then go to STEP_END.
- STEP_END (1 cycle): toggle src_bank and increment step_count.
  - If step_count+1 = latched steps, pulse done and return to IDLE.
  - Otherwise return to SWEEP with x=y=0.
- Writes always target the opposite bank: wr_addr = {~src_bank, same node index}.
- Boundary code is computed from (x,y) at issue time and carried with the node through the pipeline:
  - interior 0
  - left edge x=0: 1; right edge x=WIDTH-1: 2
  - top edge y=0: 3; bottom edge y=HEIGHT-1: 4
  - corners override edges: top-left 5, top-right 6, bottom-left 7, bottom-right 8
- Data is passed bit-exact. The block does no arithmetic on the distributions.

## Timing

- Reset values: state IDLE, src_bank 0, step_count 0, busy 0, done 0, rd_en 0, wr_en 0, rd_addr 0, wr_addr 0, col_f 0, col_bnd 0, wr_data 0, all pipeline valid bits 0.
- Pipeline for a node issued (rd_en) in cycle n:
  - rd_data is valid in cycle n+RD_LAT and is captured into col_f/col_bnd at the end of that cycle.
  - col_res is captured into wr_data at the end of cycle n+RD_LAT+1.
  - wr_en=1 in cycle n+RD_LAT+2.
  - Latency is RD_LAT+2 cycles; throughput is one node per cycle when hold=0.
- wr_en is asserted exactly once per node per step, in row-major order, with no gaps unless hold introduced them.
- col_f and col_bnd hold their last value when no node is valid.
- Sweep length with hold=0: a step takes WIDTH·HEIGHT + RD_LAT + 2 + 1 cycles from the first rd_en to STEP_END.
- The first write of step k+1 cannot precede the last write of step k, because DRAIN enforces this.
- Simultaneous events:
  - start during busy is ignored.
  - hold during DRAIN or STEP_END has no effect.
  - start in the same cycle as done is ignored. A new start is accepted from the cycle after done.
- Reset mid-run aborts immediately:
  - No further rd_en or wr_en after the reset cycle.
  - Partially written bank contents are undefined.
  - src_bank returns to 0.

## Test plan

- WIDTH=4, HEIGHT=3, RD_LAT=1, steps=1, memory returning node index in every f lane -> 12 writes to bank 1, addresses 0..11 in order, each wr_en exactly 3 cycles after its rd_en, col_bnd sequence 5,3,3,6,1,0,0,2,7,4,4,8, then a done pulse with step_count=1.
- steps=3 -> reads alternate banks 0,1,0 and writes alternate 1,0,1; done pulses once, after the 36th write; src_bank ends at 1.
- steps=0 -> done pulses in the cycle after start, and rd_en and wr_en never assert.
- hold=1 for 5 cycles after the 4th read -> rd_en gap of exactly 5 cycles, the 3 in-flight writes still complete, and the address sequence is unchanged.
- reset asserted while 2 nodes are in flight -> no wr_en afterwards, all outputs at reset values next cycle, and a following start with steps=1 runs cleanly from bank 0.
- RD_LAT=3 -> write latency of 5 cycles and correct data pairing.
